ram_responder: RTL and testbench

//   Memory-side responder for CPU load/store requests. Sits between the datapath's memory

---
 rtl/ram_responder_if.sv | 26 ++
 rtl/ram_responder.sv | 146 ++++++++++++++
 tb/tb_ram_responder.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_responder_if.sv
// Request/response bus between a CPU memory port (master) and the RAM responder (slave).
// Two independent valid/ready handshakes: one for requests, one for responses.
interface ram_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: accepts one load/store at a time, optionally waits, accesses a
// synchronous word RAM and holds the response until the requester consumes it.
module ram_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  ram_responder_if.slave bus,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state_r;
  state_t            state_s;
  logic              req_ready_r;
  logic              req_ready_s;
  logic              busy_r;
  logic              busy_s;
  logic              accept_s;
  logic              access_s;
  logic              consume_s;
  logic [3:0]        wait_cnt_r;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              rsp_valid_r;
  logic              rsp_write_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic [DATA_W-1:0] mem [DEPTH];

  // State register plus the handshake/status outputs registered from the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= req_ready_s;
      busy_r      <= busy_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 32'sd0) begin
            state_s = ST_ACCESS;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // <= rather than == so a corrupted zero count cannot lock the FSM in WAIT
        if (wait_cnt_r <= 4'd1) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode: next-cycle status values and per-edge strobes for the datapath.
  always_comb begin
    req_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
    accept_s    = (state_r == ST_IDLE) && bus.req_valid;
    access_s    = (state_r == ST_ACCESS);
    consume_s   = (state_r == ST_RESP) && bus.rsp_ready;
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r  <= 4'd0;
      write_r     <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      if (accept_s) begin
        write_r    <= bus.req_write;
        addr_r     <= bus.req_addr;
        wdata_r    <= bus.req_wdata;
        wait_cnt_r <= WAIT_INIT;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r - 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end

      if (access_s) begin
        rsp_valid_r <= 1'b1;
        rsp_write_r <= write_r;
        rsp_rdata_r <= write_r ? wdata_r : mem[addr_r];
      end else if (consume_s) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  // RAM array: no reset, so contents survive reset; a store lands only on the ACCESS edge.
  always_ff @(posedge clock) begin
    if (access_s && write_r) begin
      mem[addr_r] <= wdata_r;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_write = rsp_write_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: one DUT with one wait state, one with none.
module tb_ram_responder;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        busy1;
  logic        busy0;
  int          checks  = 0;
  int          errors  = 0;
  exp_t        sb1 [$];
  exp_t        sb0 [$];
  logic [DATA_W-1:0] model [256];

  ram_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b1 ();
  ram_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) b0 ();

  ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1.slave), .busy(busy1)
  );

  ram_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .bus(b0.slave), .busy(busy0)
  );

  always #5 clock = ~clock;

  task automatic check_reset_vals(input string name);
    checks++;
    if ({b1.req_ready, b1.rsp_valid, b1.rsp_write, b1.rsp_rdata, busy1} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL %s dut1 got rdy=%b vld=%b wr=%b rdata=%h busy=%b want 1 0 0 0000 0", name,
               b1.req_ready, b1.rsp_valid, b1.rsp_write, b1.rsp_rdata, busy1);
    end
  endtask

  task automatic issue1(input logic wr, input logic [7:0] addr, input logic [15:0] data, input bit commit);
    int n = 0;
    while (b1.req_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (b1.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout got %b want 1", b1.req_ready);
    end
    b1.req_valid = 1'b1;
    b1.req_write = wr;
    b1.req_addr  = addr;
    b1.req_wdata = data;
    if (commit) begin
      if (wr) begin
        model[addr] = data;
        sb1.push_back('{wr: 1'b1, data: data});
      end else begin
        sb1.push_back('{wr: 1'b0, data: model[addr]});
      end
    end
    @(negedge clock);
    checks++;
    if (b1.req_ready !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL accept got rdy=%b busy=%b want 0 1", b1.req_ready, busy1);
    end
    b1.req_valid = 1'b0;
    b1.req_wdata = 16'h0000;
  endtask

  task automatic wait_rsp1();
    int   n = 1;
    exp_t e;
    while (b1.rsp_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency got %0d want 3", n);
    end
    checks++;
    if (sb1.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = sb1.pop_front();
      if ({b1.rsp_write, b1.rsp_rdata} !== e) begin
        errors++;
        $display("FAIL rsp got wr=%b data=%h want wr=%b data=%h", b1.rsp_write, b1.rsp_rdata, e.wr, e.data);
      end
    end
  endtask

  task automatic ack1();
    checks++;
    if (b1.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_resp got %b want 0", b1.req_ready);
    end
    b1.rsp_ready = 1'b1;
    @(negedge clock);
    b1.rsp_ready = 1'b0;
    checks++;
    if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL release got vld=%b rdy=%b busy=%b want 0 1 0", b1.rsp_valid, b1.req_ready, busy1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    checks++;
    if ({b0.req_ready, b0.rsp_valid, b0.rsp_rdata, busy0} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_dut0 got rdy=%b vld=%b rdata=%h busy=%b want 1 0 0000 0",
               b0.req_ready, b0.rsp_valid, b0.rsp_rdata, busy0);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store();
    issue1(1'b1, 8'h05, 16'hBEEF, 1'b1);
    wait_rsp1();
    ack1();
  endtask

  task automatic test_load();
    issue1(1'b0, 8'h05, 16'h0000, 1'b1);
    wait_rsp1();
    ack1();
    issue1(1'b1, 8'h06, 16'h1234, 1'b1);
    wait_rsp1();
    ack1();
    issue1(1'b0, 8'h06, 16'h0000, 1'b1);
    wait_rsp1();
    ack1();
  endtask

  task automatic test_hold();
    issue1(1'b0, 8'h05, 16'h0000, 1'b1);
    wait_rsp1();
    b1.req_valid = 1'b1;
    b1.req_write = 1'b1;
    b1.req_addr  = 8'h05;
    b1.req_wdata = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== model[8'h05] || b1.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc %0d got vld=%b rdata=%h rdy=%b want 1 %h 0", i,
                 b1.rsp_valid, b1.rsp_rdata, b1.req_ready, model[8'h05]);
      end
    end
    b1.req_valid = 1'b0;
    ack1();
    // The request offered during RESP must not have written anything.
    issue1(1'b0, 8'h05, 16'h0000, 1'b1);
    wait_rsp1();
    ack1();
  endtask

  task automatic test_back_to_back();
    int   n = 0;
    bit   got = 1'b0;
    bit   second = 1'b0;
    exp_t e;
    @(negedge clock);
    b0.req_valid = 1'b1;
    b0.req_write = 1'b1;
    b0.req_addr  = 8'hFF;
    b0.req_wdata = 16'h00FF;
    sb0.push_back('{wr: 1'b1, data: 16'h00FF});
    @(negedge clock);
    n = 1;
    checks++;
    if (b0.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept1 got rdy=%b want 0", b0.req_ready);
    end
    b0.req_write = 1'b0;
    b0.req_wdata = 16'h0000;
    b0.rsp_ready = 1'b1;
    sb0.push_back('{wr: 1'b0, data: 16'h00FF});
    while (!second && n < 20) begin
      @(negedge clock);
      n++;
      if (!got && b0.rsp_valid === 1'b1) begin
        got = 1'b1;
        e = sb0.pop_front();
        checks++;
        if ({b0.rsp_write, b0.rsp_rdata} !== e) begin
          errors++;
          $display("FAIL b2b_store_rsp got wr=%b data=%h want wr=%b data=%h", b0.rsp_write, b0.rsp_rdata, e.wr, e.data);
        end
      end else if (got && b0.req_ready === 1'b0) begin
        second = 1'b1;
      end
    end
    b0.req_valid = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want 4 (second accept 3 edges after first)", n);
    end
    n = 0;
    while (b0.rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb0.size() == 0) begin
      errors++;
      $display("FAIL b2b_scoreboard got 0 entries want 1");
    end else begin
      e = sb0.pop_front();
      if ({b0.rsp_write, b0.rsp_rdata} !== e) begin
        errors++;
        $display("FAIL b2b_load_rsp got wr=%b data=%h want wr=%b data=%h", b0.rsp_write, b0.rsp_rdata, e.wr, e.data);
      end
    end
    @(negedge clock);
    b0.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_wait();
    issue1(1'b1, 8'h10, 16'h5555, 1'b1);
    wait_rsp1();
    ack1();
    issue1(1'b1, 8'h10, 16'hAAAA, 1'b0);
    reset_n = 1'b0;
    #1;
    check_reset_vals("reset_in_wait");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue1(1'b0, 8'h10, 16'h0000, 1'b1);
    wait_rsp1();
    ack1();
  endtask

  task automatic test_reset_resp();
    issue1(1'b1, 8'h20, 16'h1357, 1'b1);
    wait_rsp1();
    reset_n = 1'b0;
    #1;
    check_reset_vals("reset_in_resp");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    issue1(1'b0, 8'h20, 16'h0000, 1'b1);
    wait_rsp1();
    ack1();
  endtask

  initial begin
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = 8'h00; b1.req_wdata = 16'h0000; b1.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = 8'h00; b0.req_wdata = 16'h0000; b0.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 16'h0000;
    test_reset();
    test_store();
    test_load();
    test_hold();
    test_back_to_back();
    test_reset_wait();
    test_reset_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
